// File: rtl/lut_sweep_ctrl.sv
// LUT waveform sweep sequencer: paced step triggers, fixed-latency capture into a
// first-word-fall-through FIFO, and period counting. LUT_SWEEP_CONT_MODE_EN selects free-running mode.
module lut_sweep_ctrl #(
  parameter int BITWIDTH_IN  = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int BITWIDTH_DIV = 16,
  parameter int BITWIDTH_PER = 8
) (
  input  logic                    CLK_SYS,
  input  logic                    RSTN,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [BITWIDTH_DIV-1:0] CLK_DIV,
  input  logic [BITWIDTH_PER-1:0] N_PERIODS,
  output logic                    LUT_EN,
  output logic                    LUT_TRGG,
  input  logic [BITWIDTH_IN-1:0]  LUT_VALUE,
  input  logic                    LUT_END,
  output logic [BITWIDTH_IN-1:0]  DOUT,
  output logic                    DOUT_VALID,
  input  logic                    DOUT_RD,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    OVERFLOW
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;

  state_t                  state_reg, state_next;
  logic [BITWIDTH_DIV-1:0] clk_div_reg, clk_div_next;
  logic [BITWIDTH_DIV-1:0] div_cnt_reg, div_cnt_next;
  logic [BITWIDTH_PER-1:0] n_per_reg, n_per_next;
  logic [BITWIDTH_PER-1:0] per_cnt_reg, per_cnt_next;
  logic [BITWIDTH_PER-1:0] per_inc;
  logic                    cap_pending_reg, cap_pending_next;
  logic                    done_reg, done_next;
  logic                    overflow_reg, overflow_next;

  logic [BITWIDTH_IN-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        occ_reg, occ_next;

  logic trig, capture, start_ok, pop, full, push_ok;

  assign trig     = (state_reg == ST_RUN) && (div_cnt_reg == clk_div_reg);
  // The word requested by a trigger is on LUT_VALUE one cycle later; only RUN may store it.
  assign capture  = cap_pending_reg && (state_reg == ST_RUN) && !ABORT;
  assign start_ok = START && (state_reg == ST_IDLE);
  assign per_inc  = per_cnt_reg + BITWIDTH_PER'(1);

  assign pop      = DOUT_RD && (occ_reg != '0);
  assign full     = (occ_reg == CNT_W'(FIFO_DEPTH));
  assign push_ok  = capture && (!full || pop);

  always_comb begin
    state_next       = state_reg;
    clk_div_next     = clk_div_reg;
    div_cnt_next     = div_cnt_reg;
    n_per_next       = n_per_reg;
    per_cnt_next     = per_cnt_reg;
    done_next        = 1'b0;
    cap_pending_next = trig && !ABORT;
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          clk_div_next = CLK_DIV;
          n_per_next   = (N_PERIODS == '0) ? BITWIDTH_PER'(1) : N_PERIODS;
          div_cnt_next = '0;
          per_cnt_next = '0;
          state_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        div_cnt_next = trig ? '0 : div_cnt_reg + BITWIDTH_DIV'(1);
        if (capture && LUT_END) begin
`ifdef LUT_SWEEP_CONT_MODE_EN
          if (per_cnt_reg != '1) per_cnt_next = per_inc;
`else
          per_cnt_next = per_inc;
          if (per_inc == n_per_reg) state_next = ST_FINISH;
`endif
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (ABORT && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
    end
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (start_ok) overflow_next = 1'b0;
    else if (capture && full && !pop) overflow_next = 1'b1;

    occ_next = occ_reg;
    if (push_ok && !pop) occ_next = occ_reg + CNT_W'(1);
    else if (!push_ok && pop) occ_next = occ_reg - CNT_W'(1);
  end

  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      state_reg       <= ST_IDLE;
      clk_div_reg     <= '0;
      div_cnt_reg     <= '0;
      n_per_reg       <= '0;
      per_cnt_reg     <= '0;
      cap_pending_reg <= 1'b0;
      done_reg        <= 1'b0;
      overflow_reg    <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      occ_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      clk_div_reg     <= clk_div_next;
      div_cnt_reg     <= div_cnt_next;
      n_per_reg       <= n_per_next;
      per_cnt_reg     <= per_cnt_next;
      cap_pending_reg <= cap_pending_next;
      done_reg        <= done_next;
      overflow_reg    <= overflow_next;
      occ_reg         <= occ_next;
      // Depth is a power of two, so pointer increments wrap on their own.
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (push_ok) mem[wr_ptr_reg] <= LUT_VALUE;
  end

  assign LUT_EN     = (state_reg == ST_RUN);
  assign LUT_TRGG   = trig;
  assign BUSY       = (state_reg != ST_IDLE);
  assign DONE       = done_reg;
  assign OVERFLOW   = overflow_reg;
  assign DOUT_VALID = (occ_reg != '0);
  assign DOUT       = (occ_reg != '0) ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Directed bench for lut_sweep_ctrl with a behavioural LUT generator (registered, 1-cycle latency).
module tb_lut_sweep_ctrl;
  localparam int BW = 16;
  localparam int FD = 16;
  localparam int DW = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dout_rd = 1'b0;
  logic [DW-1:0] clk_div = '0;
  logic [PW-1:0] n_periods = '0;
  logic [BW-1:0] lut_value;
  logic          lut_end;
  logic          lut_en, lut_trgg, dout_valid, busy, done, overflow;
  logic [BW-1:0] dout;

  int            compared = 0;
  int            mismatched = 0;
  int            lut_len = 4;
  logic [BW-1:0] lut_base = 16'h0010;
  int            lut_idx;
  logic [BW-1:0] words_q [$];

  lut_sweep_ctrl #(
    .BITWIDTH_IN(BW), .FIFO_DEPTH(FD), .BITWIDTH_DIV(DW), .BITWIDTH_PER(PW)
  ) dut (
    .CLK_SYS(clk), .RSTN(rstn), .START(start), .ABORT(abort),
    .CLK_DIV(clk_div), .N_PERIODS(n_periods),
    .LUT_EN(lut_en), .LUT_TRGG(lut_trgg), .LUT_VALUE(lut_value), .LUT_END(lut_end),
    .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_RD(dout_rd),
    .BUSY(busy), .DONE(done), .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  // LUT generator: restarts at entry 0 whenever disabled, steps on each trigger.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lut_idx   <= 0;
      lut_value <= '0;
      lut_end   <= 1'b0;
    end else if (!lut_en) begin
      lut_idx <= 0;
    end else if (lut_trgg) begin
      lut_value <= lut_base + BW'(lut_idx);
      lut_end   <= (lut_idx == lut_len - 1);
      lut_idx   <= (lut_idx == lut_len - 1) ? 0 : lut_idx + 1;
    end
  end

  // All tasks enter and leave on a falling edge.
  task automatic start_run(input int div, input int np);
    clk_div   = DW'(div);
    n_periods = PW'(np);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic drain_fifo(input int max_cycles);
    words_q.delete();
    dout_rd = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (dout_valid) begin
        words_q.push_back(dout);
        $display("drain pop word=%h", dout);
      end
      @(negedge clk);
    end
    dout_rd = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({lut_en, lut_trgg, busy, done, overflow, dout_valid, dout} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got en/trg/busy/done/ovf/vld=%b%b%b%b%b%b dout=%h required all 0",
               lut_en, lut_trgg, busy, done, overflow, dout_valid, dout);
    end
    rstn = 1'b1;
    @(negedge clk);
    $display("reset released busy=%b", busy);
  endtask

  task automatic test_reset_mid_run();
    int n_trg;
    start_run(3, 2);
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    compared++;
    if ({lut_en, lut_trgg, busy, done, overflow, dout_valid, dout} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_run: got en/trg/busy/done/ovf/vld=%b%b%b%b%b%b dout=%h required all 0",
               lut_en, lut_trgg, busy, done, overflow, dout_valid, dout);
    end
    @(negedge clk);
    rstn = 1'b1;
    n_trg = 0;
    repeat (10) begin
      @(negedge clk);
      if (lut_trgg) n_trg++;
    end
    compared++;
    if (n_trg !== 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_run_after: got triggers=%0d busy=%b required 0 and 0", n_trg, busy);
    end
    $display("reset mid-run triggers after release=%0d", n_trg);
  endtask

  task automatic test_basic_sweep();
    int trg, last_trg, spacing_bad, done_cnt, busy_at_done;
    logic seen_done;
    logic [BW-1:0] exp_w;
    lut_len = 4; lut_base = 16'h0010; dout_rd = 1'b1;
    words_q.delete();
    trg = 0; last_trg = -1; spacing_bad = 0; done_cnt = 0; busy_at_done = 1; seen_done = 1'b0;
    start_run(2, 2);
    for (int i = 0; i < 80 && !seen_done; i++) begin
      if (dout_valid) begin
        words_q.push_back(dout);
        $display("sweep pop word=%h", dout);
      end
      if (lut_trgg) begin
        if (last_trg >= 0 && i - last_trg != 3) spacing_bad++;
        last_trg = i;
        trg++;
      end
      if (done) begin done_cnt++; seen_done = 1'b1; busy_at_done = busy; end
      @(negedge clk);
    end
    repeat (5) begin
      if (done) done_cnt++;
      if (dout_valid) words_q.push_back(dout);
      @(negedge clk);
    end
    dout_rd = 1'b0;
    compared++;
    if (!seen_done || done_cnt != 1) begin
      mismatched++;
      $display("FAIL sweep_done: got seen=%b pulses=%0d required 1 and 1", seen_done, done_cnt);
    end
    compared++;
    if (trg != 8 || spacing_bad != 0) begin
      mismatched++;
      $display("FAIL sweep_trigger: got count=%0d bad_spacing=%0d required 8 and 0", trg, spacing_bad);
    end
    compared++;
    if (busy_at_done != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL sweep_busy: got at_done=%0d after=%b required 0", busy_at_done, busy);
    end
    compared++;
    if (words_q.size() != 8) begin
      mismatched++;
      $display("FAIL sweep_count: got %0d words required 8", words_q.size());
    end
    for (int k = 0; k < 8 && k < words_q.size(); k++) begin
      exp_w = 16'h0010 + BW'(k % 4);
      compared++;
      if (words_q[k] !== exp_w) begin
        mismatched++;
        $display("FAIL sweep_word[%0d]: got %h required %h", k, words_q[k], exp_w);
      end
    end
  endtask

  task automatic test_div0();
    int en_cycles, trg_low, done_cnt;
    logic [BW-1:0] exp_w;
    lut_len = 4; lut_base = 16'h0010; dout_rd = 1'b1;
    words_q.delete();
    en_cycles = 0; trg_low = 0; done_cnt = 0;
    start_run(0, 0);
    for (int i = 0; i < 20; i++) begin
      if (dout_valid) begin
        words_q.push_back(dout);
        $display("div0 pop word=%h", dout);
      end
      if (lut_en) begin
        en_cycles++;
        if (!lut_trgg) trg_low++;
      end
      if (done) done_cnt++;
      @(negedge clk);
    end
    dout_rd = 1'b0;
    compared++;
    if (en_cycles != 5 || trg_low != 0) begin
      mismatched++;
      $display("FAIL div0_trigger: got run_cycles=%0d low_cycles=%0d required 5 and 0", en_cycles, trg_low);
    end
    compared++;
    if (done_cnt != 1 || words_q.size() != 4) begin
      mismatched++;
      $display("FAIL div0_count: got done=%0d words=%0d required 1 and 4", done_cnt, words_q.size());
    end
    for (int k = 0; k < 4 && k < words_q.size(); k++) begin
      exp_w = 16'h0010 + BW'(k);
      compared++;
      if (words_q[k] !== exp_w) begin
        mismatched++;
        $display("FAIL div0_word[%0d]: got %h required %h", k, words_q[k], exp_w);
      end
    end
  endtask

  task automatic test_overflow();
    logic seen_done;
    lut_len = 32; lut_base = 16'h0000; dout_rd = 1'b0;
    seen_done = 1'b0;
    start_run(0, 1);
    for (int i = 0; i < 100 && !seen_done; i++) begin
      if (done) seen_done = 1'b1;
      else @(negedge clk);
    end
    compared++;
    if (!seen_done || overflow !== 1'b1 || dout_valid !== 1'b1 || dout !== 16'h0000) begin
      mismatched++;
      $display("FAIL overflow_set: got done=%b ovf=%b vld=%b head=%h required 1 1 1 0000",
               seen_done, overflow, dout_valid, dout);
    end
    start_run(5, 1);
    compared++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow_clear: got ovf=%b busy=%b required 0 and 1", overflow, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain_fifo(40);
    compared++;
    if (words_q.size() != 16) begin
      mismatched++;
      $display("FAIL overflow_count: got %0d words required 16", words_q.size());
    end
    for (int k = 0; k < 16 && k < words_q.size(); k++) begin
      compared++;
      if (words_q[k] !== BW'(k)) begin
        mismatched++;
        $display("FAIL overflow_word[%0d]: got %h required %h", k, words_q[k], BW'(k));
      end
    end
  endtask

  task automatic test_full_push_pop();
    int pushes;
    logic trg_prev, cap_now, found;
    lut_len = 32; lut_base = 16'h0100; dout_rd = 1'b0;
    pushes = 0; trg_prev = 1'b0; found = 1'b0;
    start_run(1, 1);
    for (int i = 0; i < 100 && !found; i++) begin
      cap_now  = trg_prev;
      trg_prev = lut_trgg;
      if (cap_now && pushes == 16) begin
        found = 1'b1;
      end else begin
        if (cap_now) pushes++;
        @(negedge clk);
      end
    end
    compared++;
    if (!found || dout_valid !== 1'b1 || dout !== 16'h0100 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL full_before: got found=%b vld=%b head=%h ovf=%b required 1 1 0100 0",
               found, dout_valid, dout, overflow);
    end
    dout_rd = 1'b1;
    @(negedge clk);
    dout_rd = 1'b0;
    compared++;
    if (overflow !== 1'b0 || dout !== 16'h0101 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL full_push_pop: got ovf=%b head=%h busy=%b required 0 0101 1", overflow, dout, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain_fifo(40);
    compared++;
    if (words_q.size() != 16) begin
      mismatched++;
      $display("FAIL full_count: got %0d words required 16", words_q.size());
    end
    for (int k = 0; k < 16 && k < words_q.size(); k++) begin
      compared++;
      if (words_q[k] !== 16'h0101 + BW'(k)) begin
        mismatched++;
        $display("FAIL full_word[%0d]: got %h required %h", k, words_q[k], 16'h0101 + BW'(k));
      end
    end
  endtask

  task automatic test_abort_start();
    int done_cnt;
    lut_len = 4; lut_base = 16'h0010; dout_rd = 1'b1;
    start_run(2, 3);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    compared++;
    if ({busy, lut_en, done} !== 3'b000) begin
      mismatched++;
      $display("FAIL abort_idle: got busy/en/done=%b%b%b required 000", busy, lut_en, done);
    end
    @(negedge clk);
    start = 1'b0;
    compared++;
    if ({busy, lut_en, done} !== 3'b110) begin
      mismatched++;
      $display("FAIL abort_restart: got busy/en/done=%b%b%b required 110", busy, lut_en, done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    done_cnt = 0;
    repeat (4) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    compared++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_no_done: got done=%0d busy=%b required 0 and 0", done_cnt, busy);
    end
    drain_fifo(20);
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic_sweep();
    test_div0();
    test_overflow();
    test_full_push_pop();
    test_abort_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lut_sweep_ctrl.md
Name: lut_sweep_ctrl

Overview:
Sequencer for the LUT waveform-generator datapath inside the ROM test skeleton. On a host START it enables the LUT and issues sample-step triggers at a programmable rate. It captures each LUT output word into a small FIFO and counts completed LUT periods (LUT_END) until the requested number is reached. The host drains the FIFO over a valid/read handshake; BUSY/DONE/OVERFLOW report status to the skeleton header logic.

Parameters:
BITWIDTH_IN, 16, width of LUT_VALUE / DOUT
FIFO_DEPTH, 16, capture FIFO depth in words; power of two, >=2
BITWIDTH_DIV, 16, width of CLK_DIV step divider
BITWIDTH_PER, 8, width of N_PERIODS period counter

Ports:
CLK_SYS  in  1  system clock, all logic rising-edge
RSTN  in  1  asynchronous active-low reset
START  in  1  one-cycle start request; honoured only in IDLE
ABORT  in  1  one-cycle abort; any state -> IDLE next cycle
CLK_DIV  in  BITWIDTH_DIV  trigger period minus 1, in CLK_SYS cycles; latched on START
N_PERIODS  in  BITWIDTH_PER  LUT periods to run; latched on START; 0 treated as 1
LUT_EN  out  1  enable to LUT generator
LUT_TRGG  out  1  one-cycle step trigger to LUT generator
LUT_VALUE  in  BITWIDTH_IN  LUT output word
LUT_END  in  1  LUT last-entry flag, valid with LUT_VALUE
DOUT  out  BITWIDTH_IN  FIFO head word
DOUT_VALID  out  1  FIFO not empty
DOUT_RD  in  1  pop FIFO head; ignored when DOUT_VALID=0
BUSY  out  1  high in RUN and FINISH
DONE  out  1  one-cycle pulse on FINISH->IDLE
OVERFLOW  out  1  sticky: capture dropped on full FIFO; cleared by accepted START

Behaviour:
- Reset (RSTN=0, async): state IDLE; LUT_EN=0, LUT_TRGG=0, BUSY=0, DONE=0, OVERFLOW=0; FIFO empty (DOUT_VALID=0, DOUT=0); all counters 0.
- States: IDLE, RUN, FINISH.
- IDLE: START=1 -> latch CLK_DIV/N_PERIODS, clear OVERFLOW, divider=0, period count=0 -> RUN. FIFO contents are not flushed.
- RUN: LUT_EN=1. Divider counts 0..CLK_DIV. LUT_TRGG pulses for one cycle when divider==CLK_DIV, then the divider wraps to 0. With CLK_DIV=0, LUT_TRGG stays high every cycle. The first trigger comes CLK_DIV+1 cycles after entering RUN.
- Capture: LUT_VALUE/LUT_END are sampled exactly 1 cycle after each LUT_TRGG (fixed LUT latency), then pushed to the FIFO.
- Period count: a capture with LUT_END=1 increments the period count. When the incremented count equals max(N_PERIODS,1) -> FINISH. The triggering word is still written.
- FINISH: LUT_EN=0, no triggers, one cycle, then -> IDLE with DONE=1 for that cycle.
- ABORT: from RUN/FINISH -> IDLE next cycle, LUT_EN=0, no DONE, pending capture discarded. ABORT has priority over START and capture in the same cycle. ABORT in IDLE has no effect.
- START while BUSY is ignored.
- FIFO: first-word-fall-through; DOUT shows the head whenever DOUT_VALID=1. Pop happens on DOUT_RD && DOUT_VALID.
  - Push and pop in the same cycle are both accepted, including when full; occupancy is unchanged.
  - Push when full without a pop: word dropped, OVERFLOW=1 (sticky).
  - Pointers wrap modulo FIFO_DEPTH. A separate occupancy counter 0..FIFO_DEPTH distinguishes full from empty.
- Width rules: divider and period counters are unsigned and do not overflow, because comparisons use equality with the latched values.

Optional Feature:
Macro LUT_SWEEP_CONT_MODE_EN.
- Defined: N_PERIODS is ignored; RUN continues until ABORT, the period counter saturates at all-ones, and FINISH/DONE are never reached.
- Undefined: behaviour exactly as above.

Test Plan:
- Reset mid-RUN: CLK_DIV=3, N_PERIODS=2, START, drop RSTN after 10 cycles -> all outputs 0 immediately; DOUT_VALID=0; no LUT_TRGG after RSTN release.
- Basic sweep: LUT model of 4 entries (values 0x0010..0x0013, LUT_END on the 4th), CLK_DIV=2, N_PERIODS=2, DOUT_RD=1 -> LUT_TRGG every 3 cycles, 8 words popped in order 0x10,0x11,0x12,0x13,0x10,...; DONE pulses once; BUSY low after.
- CLK_DIV=0, N_PERIODS=0: LUT_TRGG high continuously, exactly one period (4 words) captured, then DONE.
- Overflow: FIFO_DEPTH=16, 32-entry LUT, DOUT_RD=0, CLK_DIV=0 -> first 16 words retained (0..15), OVERFLOW=1. The next START clears OVERFLOW, and the FIFO still holds 16 words.
- Full + simultaneous push/pop: FIFO full, DOUT_RD=1 on a capture cycle -> occupancy stays 16, OVERFLOW stays 0, no word lost.
- ABORT and START in the same cycle during RUN -> IDLE next cycle, LUT_EN=0, no DONE. A START one cycle later is accepted and BUSY=1.
